// File: rtl/home_req_scheduler.sv
// home_req_scheduler: round-robin accept of client requests, invalidate probes, then grant to the home node
module home_req_scheduler #(
  parameter int N_CLIENTS = 3,
  parameter int CMD_W     = 3,
  parameter int CLI_W     = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_CLIENTS-1:0]       req_valid,
  input  logic [N_CLIENTS*CMD_W-1:0] req_cmd,
  output logic [N_CLIENTS-1:0]       req_ready,
  input  logic [N_CLIENTS-1:0]       sharer_list,
  input  logic                       excl_granted,
  output logic [N_CLIENTS-1:0]       probe_valid,
  input  logic [N_CLIENTS-1:0]       probe_ack,
  output logic                       grant_valid,
  output logic                       grant_excl,
  input  logic                       grant_ack,
  output logic                       busy,
  output logic [CLI_W-1:0]           cur_client,
  output logic [CMD_W-1:0]           cur_cmd,
  output logic                       cmd_err
);
  localparam logic [CMD_W-1:0] ACQ_S = CMD_W'(1);
  localparam logic [CMD_W-1:0] ACQ_E = CMD_W'(2);
  typedef enum logic [1:0] {IDLE, PROBE, GRANT} state_t;
  state_t                 state, state_nx;
  logic                   found, legal, err_nx;
  logic [CLI_W-1:0]       winner, last_winner, lw_nx, cli_nx;
  logic [CMD_W-1:0]       win_cmd, cmd_nx;
  logic [N_CLIENTS-1:0]   own, inv_acc, inv_list, inv_nx;
  // scan starts just after the previous winner so every client gets a turn
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= N_CLIENTS; k++) begin
      if (!found && req_valid[(int'(last_winner) + k) % N_CLIENTS]) begin
        found  = 1'b1;
        winner = CLI_W'((int'(last_winner) + k) % N_CLIENTS);
      end
    end
  end
  assign own     = N_CLIENTS'(1) << winner;
  assign win_cmd = req_cmd[int'(winner)*CMD_W +: CMD_W];
  assign legal   = (win_cmd == ACQ_S) || (win_cmd == ACQ_E);
  assign inv_acc = (win_cmd == ACQ_E || (win_cmd == ACQ_S && excl_granted)) ? sharer_list & ~own : '0;
  assign req_ready   = (state == IDLE && found) ? own : '0;
  assign probe_valid = (state == PROBE) ? inv_list : '0;
  assign grant_valid = state == GRANT;
  assign grant_excl  = grant_valid && cur_cmd == ACQ_E;
  assign busy        = state != IDLE;
  always_comb begin
    state_nx = state;
    inv_nx   = inv_list;
    err_nx   = cmd_err;
    cli_nx   = cur_client;
    cmd_nx   = cur_cmd;
    lw_nx    = last_winner;
    if (state == IDLE && found) begin
      cli_nx   = winner;
      cmd_nx   = win_cmd;
      lw_nx    = winner;
      inv_nx   = inv_acc;
      err_nx   = cmd_err | ~legal;
      state_nx = !legal ? IDLE : (|inv_acc) ? PROBE : GRANT;
    end else if (state == PROBE) begin
      inv_nx   = inv_list & ~probe_ack;
      state_nx = (|inv_nx) ? PROBE : GRANT;
    end else if (state == GRANT && grant_ack) begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      inv_list    <= '0;
      cmd_err     <= 1'b0;
      cur_client  <= '0;
      cur_cmd     <= '0;
      last_winner <= CLI_W'(N_CLIENTS - 1);
    end else begin
      state       <= state_nx;
      inv_list    <= inv_nx;
      cmd_err     <= err_nx;
      cur_client  <= cli_nx;
      cur_cmd     <= cmd_nx;
      last_winner <= lw_nx;
    end
  end
endmodule

// File: tb/tb_home_req_scheduler.sv
// tb_home_req_scheduler: directed and randomized transactions checked against a transaction-level model
module tb_home_req_scheduler;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] req_valid = '0;
  logic [8:0] req_cmd = '0;
  logic [2:0] req_ready, sharer_list = '0, probe_valid, probe_ack = '0;
  logic       excl_granted = 1'b0, grant_valid, grant_excl, grant_ack = 1'b0, busy, cmd_err;
  logic [1:0] cur_client;
  logic [2:0] cur_cmd;
  int checks = 0, failures = 0;
  int lw = 2;
  logic err_m = 1'b0;
  logic [2:0] ack_q[$];

  home_req_scheduler dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_ready(req_ready), .sharer_list(sharer_list), .excl_granted(excl_granted),
    .probe_valid(probe_valid), .probe_ack(probe_ack), .grant_valid(grant_valid),
    .grant_excl(grant_excl), .grant_ack(grant_ack), .busy(busy),
    .cur_client(cur_client), .cur_cmd(cur_cmd), .cmd_err(cmd_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [2:0] v);
    for (int k = 1; k <= 3; k++)
      if (v[(lw + k) % 3]) return (lw + k) % 3;
    return -1;
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic run_txn(input logic [2:0] v, input logic [8:0] cmds, input logic [2:0] sh,
                         input logic ex, input int hold);
    int w;
    int n;
    logic [2:0] cmd, own, inv, pend, ack;
    logic legal;
    w = pick(v);
    cmd = cmds[w*3 +: 3];
    own = 3'(1 << w);
    legal = (cmd == 3'd1) || (cmd == 3'd2);
    inv = (cmd == 3'd2 || (cmd == 3'd1 && ex)) ? sh & ~own : 3'b000;
    req_valid = v; req_cmd = cmds; sharer_list = sh; excl_granted = ex;
    @(negedge clock);
    chk("accept_ready", req_ready, own);
    chk("accept_busy", busy, 0);
    next_cycle();
    req_valid = '0;
    lw = w;
    if (!legal) begin
      err_m = 1'b1;
      @(negedge clock);
      chk("illegal_busy", busy, 0);
      chk("illegal_err", cmd_err, 1);
      chk("illegal_grant", grant_valid, 0);
      chk("illegal_probe", probe_valid, 0);
      next_cycle();
      return;
    end
    pend = inv;
    n = 0;
    while (pend != 0 && n < 20) begin
      ack = ack_q.size() != 0 ? ack_q.pop_front() : (n > 4 ? pend : 3'($urandom));
      probe_ack = ack;
      grant_ack = 1'($urandom);
      @(negedge clock);
      chk("probe_valid", probe_valid, pend);
      chk("probe_nogrant", grant_valid, 0);
      chk("probe_ready", req_ready, 0);
      next_cycle();
      pend &= ~ack;
      n++;
    end
    probe_ack = '0;
    grant_ack = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      req_valid = 3'($urandom_range(1, 7));
      grant_ack = (h == hold);
      @(negedge clock);
      chk("grant_valid", grant_valid, 1);
      chk("grant_excl", grant_excl, cmd == 3'd2);
      chk("cur_client", cur_client, w);
      chk("cur_cmd", cur_cmd, cmd);
      chk("grant_ready", req_ready, 0);
      chk("grant_probe", probe_valid, 0);
      next_cycle();
    end
    grant_ack = 1'b0;
    req_valid = '0;
    @(negedge clock);
    chk("done_busy", busy, 0);
    chk("done_grant", grant_valid, 0);
    chk("done_err", cmd_err, err_m);
    next_cycle();
  endtask

  initial begin
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_client", cur_client, 0);
    chk("rst_err", cmd_err, 0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    // round-robin over three shared requests
    for (int i = 0; i < 3; i++) run_txn(3'b111, {3'd1, 3'd1, 3'd1}, 3'b000, 1'b0, 0);
    // exclusive with ordered acks
    ack_q.push_back(3'b001); ack_q.push_back(3'b100);
    run_txn(3'b010, {3'd0, 3'd2, 3'd0}, 3'b111, 1'b0, 0);
    // shared against exclusive owner, simultaneous acks with a stray bit
    ack_q.push_back(3'b110);
    run_txn(3'b001, {3'd0, 3'd0, 3'd1}, 3'b100, 1'b1, 0);
    // illegal command
    run_txn(3'b100, {3'b101, 3'd0, 3'd0}, 3'b000, 1'b0, 0);
    // reset in the middle of probing
    req_valid = 3'b100; req_cmd = {3'd2, 3'd0, 3'd0}; sharer_list = 3'b011; excl_granted = 1'b0;
    next_cycle();
    req_valid = '0;
    @(negedge clock);
    chk("mid_probe", probe_valid, 3'b011);
    #1 reset = 1'b0;
    #1;
    chk("arst_probe", probe_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_grant", grant_valid, 0);
    chk("arst_excl", grant_excl, 0);
    chk("arst_client", cur_client, 0);
    chk("arst_cmd", cur_cmd, 0);
    chk("arst_err", cmd_err, 0);
    lw = 2; err_m = 1'b0;
    next_cycle();
    reset = 1'b1;
    run_txn(3'b111, {3'd1, 3'd1, 3'd1}, 3'b000, 1'b0, 0);
    // grant held while other clients wait
    run_txn(3'b110, {3'd1, 3'd2, 3'd0}, 3'b000, 1'b0, 5);
    for (int i = 0; i < 40; i++) begin
      logic [8:0] c;
      for (int j = 0; j < 3; j++) c[j*3 +: 3] = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(1, 2));
      run_txn(3'($urandom_range(1, 7)), c, 3'($urandom), 1'($urandom), $urandom_range(0, 2));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
